// File: rtl/ansi_csi_parser.sv
// ansi_csi_parser
//   Byte-stream escape decoder sitting between uart_rx and the terminal
//   writer. Printable and C0 bytes pass straight through as char pulses.
//   Two-byte ESC sequences become an esc pulse. CSI sequences
//   (ESC [ params final) become one csi pulse that carries the final
//   byte, the private-marker flag and up to MAX_PARAMS numeric
//   parameters. Parameters saturate at 2^PARAM_W-1.
//
// Ports
//   clk100       in   system clock
//   rst          in   synchronous active-high reset
//   rx_data      in   received byte, meaningful only while rx_valid=1
//   rx_valid     in   one-cycle pulse per byte; may be high every cycle
//   char_valid   out  pulse: pass-through byte on char_data
//   char_data    out  printable or C0 byte
//   esc_valid    out  pulse: ESC x sequence completed
//   esc_final    out  final byte of the ESC sequence
//   csi_valid    out  pulse: CSI sequence completed
//   csi_final    out  CSI final byte (0x40-0x7E)
//   csi_private  out  first byte after '[' was 0x3C-0x3F
//   csi_nparams  out  parameters received, saturating at MAX_PARAMS
//   csi_params   out  param i at [i*PARAM_W +: PARAM_W]; missing = 0
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: every input byte is accepted in the cycle rx_valid is high
// (there is no back-pressure). Each output pulse is registered and appears
// exactly one cycle after the rx_valid cycle that caused it. At most one
// pulse is high per cycle. Data outputs hold until the next pulse of the
// same kind.
module ansi_csi_parser #(
    parameter int  MAX_PARAMS = 4,
    parameter int  PARAM_W    = 8,
    localparam int NP_W       = $clog2(MAX_PARAMS + 1),
    localparam int PV_W       = MAX_PARAMS * PARAM_W
) (
    input  logic            clk100,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            char_valid,
    output logic [7:0]      char_data,
    output logic            esc_valid,
    output logic [7:0]      esc_final,
    output logic            csi_valid,
    output logic [7:0]      csi_final,
    output logic            csi_private,
    output logic [NP_W-1:0] csi_nparams,
    output logic [PV_W-1:0] csi_params,
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        GROUND     = 3'd0,
        ESC        = 3'd1,
        CSI_ENTRY  = 3'd2,
        CSI_PARAM  = 3'd3,
        CSI_IGNORE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PARAM_W-1:0] cur_q, cur_d;      // parameter being accumulated
    logic [NP_W-1:0]   idx_q, idx_d;       // slot index, saturates at MAX_PARAMS
    logic              seen_q, seen_d;     // any digit or ';' seen in this CSI
    logic              priv_q, priv_d;
    logic [PV_W-1:0]   slots_q, slots_d;   // committed parameters of this CSI

    logic              char_valid_q, char_valid_d;
    logic [7:0]        char_data_q, char_data_d;
    logic              esc_valid_q, esc_valid_d;
    logic [7:0]        esc_final_q, esc_final_d;
    logic              csi_valid_q, csi_valid_d;
    logic [7:0]        csi_final_q, csi_final_d;
    logic              csi_private_q, csi_private_d;
    logic [NP_W-1:0]   csi_nparams_q, csi_nparams_d;
    logic [PV_W-1:0]   csi_params_q, csi_params_d;

    // Byte classes
    logic is_c0, is_digit, is_semi, is_final, is_inter, is_priv_mark;
    assign is_c0        = (rx_data < 8'h20);
    assign is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_semi      = (rx_data == 8'h3B);
    assign is_final     = (rx_data >= 8'h40) && (rx_data <= 8'h7E);
    assign is_inter     = (rx_data >= 8'h20) && (rx_data <= 8'h2F);
    assign is_priv_mark = (rx_data >= 8'h3C) && (rx_data <= 8'h3F);

    // Parameter arithmetic helpers
    logic [PARAM_W+3:0] cur_ext, cur_mul;
    logic [PARAM_W-1:0] cur_sat;
    logic [PV_W-1:0]    slots_commit;
    logic [NP_W-1:0]    idx_inc;
    logic [NP_W-1:0]    nparams_fin;

    always_comb begin
        cur_ext = {4'b0, cur_q};
        // cur*10 + digit; four extra bits cannot overflow for cur <= 2^PARAM_W-1
        cur_mul = (cur_ext << 3) + (cur_ext << 1) + {{PARAM_W{1'b0}}, rx_data[3:0]};
        if (cur_mul > {4'b0, {PARAM_W{1'b1}}}) begin
            cur_sat = {PARAM_W{1'b1}};
        end else begin
            cur_sat = cur_mul[PARAM_W-1:0];
        end

        // Commit writes cur only into an existing slot; later params are dropped
        slots_commit = slots_q;
        for (int i = 0; i < MAX_PARAMS; i++) begin
            if (idx_q == NP_W'(i)) begin
                slots_commit[i*PARAM_W +: PARAM_W] = cur_q;
            end
        end

        if (idx_q == NP_W'(MAX_PARAMS)) begin
            idx_inc = idx_q;
        end else begin
            idx_inc = idx_q + NP_W'(1);
        end

        if (!seen_q) begin
            nparams_fin = '0;
        end else if (idx_q >= NP_W'(MAX_PARAMS - 1)) begin
            nparams_fin = NP_W'(MAX_PARAMS);
        end else begin
            nparams_fin = idx_q + NP_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        idx_d         = idx_q;
        seen_d        = seen_q;
        priv_d        = priv_q;
        slots_d       = slots_q;
        char_valid_d  = 1'b0;
        char_data_d   = char_data_q;
        esc_valid_d   = 1'b0;
        esc_final_d   = esc_final_q;
        csi_valid_d   = 1'b0;
        csi_final_d   = csi_final_q;
        csi_private_d = csi_private_q;
        csi_nparams_d = csi_nparams_q;
        csi_params_d  = csi_params_q;

        if (rx_valid) begin
            if (rx_data == 8'h18 || rx_data == 8'h1A) begin
                state_d = GROUND;
            end else if (rx_data == 8'h1B) begin
                state_d = ESC;
                cur_d   = '0;
                idx_d   = '0;
                seen_d  = 1'b0;
                priv_d  = 1'b0;
                slots_d = '0;
            end else begin
                unique case (state_q)
                    GROUND: begin
                        if (rx_data < 8'h7F) begin
                            char_valid_d = 1'b1;
                            char_data_d  = rx_data;
                        end
                    end
                    ESC: begin
                        if (rx_data == 8'h5B) begin
                            state_d = CSI_ENTRY;
                            cur_d   = '0;
                            idx_d   = '0;
                            seen_d  = 1'b0;
                            priv_d  = 1'b0;
                            slots_d = '0;
                        end else if (rx_data >= 8'h30 && rx_data <= 8'h7E) begin
                            esc_valid_d = 1'b1;
                            esc_final_d = rx_data;
                            state_d     = GROUND;
                        end else if (is_c0) begin
                            char_valid_d = 1'b1;
                            char_data_d  = rx_data;
                        end else begin
                            state_d = GROUND;
                        end
                    end
                    CSI_ENTRY, CSI_PARAM: begin
                        // A private marker is only special as the first byte
                        if (state_q == CSI_ENTRY && is_priv_mark) begin
                            priv_d  = 1'b1;
                            state_d = CSI_PARAM;
                        end else if (is_digit) begin
                            cur_d   = cur_sat;
                            seen_d  = 1'b1;
                            state_d = CSI_PARAM;
                        end else if (is_semi) begin
                            slots_d = slots_commit;
                            idx_d   = idx_inc;
                            cur_d   = '0;
                            seen_d  = 1'b1;
                            state_d = CSI_PARAM;
                        end else if (is_final) begin
                            csi_valid_d   = 1'b1;
                            csi_final_d   = rx_data;
                            csi_private_d = priv_q;
                            csi_nparams_d = nparams_fin;
                            csi_params_d  = slots_commit;
                            state_d       = GROUND;
                        end else if (rx_data == 8'h3A || is_priv_mark || is_inter) begin
                            state_d = CSI_IGNORE;
                        end else if (is_c0) begin
                            char_valid_d = 1'b1;
                            char_data_d  = rx_data;
                        end
                        // 0x7F and 0x80-0xFF are ignored without a state change
                    end
                    CSI_IGNORE: begin
                        if (is_final) begin
                            state_d = GROUND;
                        end else if (is_c0) begin
                            char_valid_d = 1'b1;
                            char_data_d  = rx_data;
                        end
                    end
                    default: state_d = GROUND;
                endcase
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q       <= GROUND;
            cur_q         <= '0;
            idx_q         <= '0;
            seen_q        <= 1'b0;
            priv_q        <= 1'b0;
            slots_q       <= '0;
            char_valid_q  <= 1'b0;
            char_data_q   <= '0;
            esc_valid_q   <= 1'b0;
            esc_final_q   <= '0;
            csi_valid_q   <= 1'b0;
            csi_final_q   <= '0;
            csi_private_q <= 1'b0;
            csi_nparams_q <= '0;
            csi_params_q  <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            idx_q         <= idx_d;
            seen_q        <= seen_d;
            priv_q        <= priv_d;
            slots_q       <= slots_d;
            char_valid_q  <= char_valid_d;
            char_data_q   <= char_data_d;
            esc_valid_q   <= esc_valid_d;
            esc_final_q   <= esc_final_d;
            csi_valid_q   <= csi_valid_d;
            csi_final_q   <= csi_final_d;
            csi_private_q <= csi_private_d;
            csi_nparams_q <= csi_nparams_d;
            csi_params_q  <= csi_params_d;
        end
    end

    assign char_valid  = char_valid_q;
    assign char_data   = char_data_q;
    assign esc_valid   = esc_valid_q;
    assign esc_final   = esc_final_q;
    assign csi_valid   = csi_valid_q;
    assign csi_final   = csi_final_q;
    assign csi_private = csi_private_q;
    assign csi_nparams = csi_nparams_q;
    assign csi_params  = csi_params_q;
    assign dbg_state_o = state_q;

endmodule
